// File: rtl/regfile_pkg.sv
// Types and default sizing shared by the register file and its storage array.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_NRD    = 2;

endpackage

// File: rtl/rf_array.sv
// Register storage with two write ports (port 1 wins on a same-address collision)
// and a single-entry zeroing port used by the clear sequencer.
module rf_array
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_idx_i,
  input  logic              we0_i,
  input  logic [AW-1:0]     wa0_i,
  input  logic [DATA_W-1:0] wd0_i,
  input  logic              we1_i,
  input  logic [AW-1:0]     wa1_i,
  input  logic [DATA_W-1:0] wd1_i,
  output logic [DATA_W-1:0] mem_o [NREGS]
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Contents are deliberately not reset; the clear sequencer zeroes them.
  // The later assignment to port 1 gives it priority on an address collision.
  always_ff @(posedge clk_i) begin
    if (clr_en_i) begin
      mem_q[clr_idx_i] <= '0;
    end else begin
      if (we0_i) mem_q[wa0_i] <= wd0_i;
      if (we1_i) mem_q[wa1_i] <= wd1_i;
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      mem_o[i] = mem_q[i];
    end
  end

endmodule

// File: rtl/regfile_np.sv
// Multi-read-port register file with a PC alias at the top index, optional write bypass,
// and a one-register-per-cycle clear sequencer that runs after reset and on request.
module regfile_np
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NRD    = DEF_NRD,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                ready,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [DATA_W-1:0]   wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [DATA_W-1:0]   wd1,
  input  logic [NRD*AW-1:0]   ra,
  input  logic [DATA_W-1:0]   pc_in,
  output logic [NRD*DATA_W-1:0] rd
);

  localparam logic [AW-1:0] PC_IDX = AW'(NREGS - 1);

  rf_state_e         state_q;
  logic [AW-1:0]     clr_idx_q;
  logic              ready_q;
  logic              wr0_ok;
  logic              wr1_ok;
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == PC_IDX) begin
            state_q   <= ST_RUN;
            clr_idx_q <= '0;
            ready_q   <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        ST_RUN: begin
          clr_idx_q <= '0;
          if (clr_req) begin
            state_q <= ST_CLEAR;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_idx_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;

  // PC is owned externally, so writes aimed at its index never reach the array.
  assign wr0_ok = ready_q && we0 && (wa0 != PC_IDX);
  assign wr1_ok = ready_q && we1 && (wa1 != PC_IDX);

  rf_array #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_array (
    .clk_i     (clk),
    .clr_en_i  (state_q == ST_CLEAR),
    .clr_idx_i (clr_idx_q),
    .we0_i     (wr0_ok),
    .wa0_i     (wa0),
    .wd0_i     (wd0),
    .we1_i     (wr1_ok),
    .wa1_i     (wa1),
    .wd1_i     (wd1),
    .mem_o     (mem)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;

    assign addr = ra[k*AW +: AW];

    // wr*_ok already folds in ready and the PC exclusion, so bypass is off while clearing.
    always_comb begin
      data = mem[addr];
      if (addr == PC_IDX) begin
        data = pc_in;
      end else if ((BYPASS != 0) && wr1_ok && (wa1 == addr)) begin
        data = wd1;
      end else if ((BYPASS != 0) && wr0_ok && (wa0 == addr)) begin
        data = wd0;
      end
    end

    assign rd[k*DATA_W +: DATA_W] = data;
  end

endmodule
